// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: mode encoding
// and default geometry used by the channel and top-level modules.
package clk_div_pkg;

    // Output shaping selected per channel; sampled into the channel's
    // shadow mode only at a period boundary or on a phase restart.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,   // 50 % duty, period = 2 * div
        MODE_PULSE  = 1'b1    // one cycle high, period = div
    } mode_e;

    localparam int DEF_W   = 32;
    localparam int DEF_NCH = 4;

endpackage

// File: rtl/clk_div_chan.sv
// Single divider channel. The active scale/mode are shadow copies of the
// inputs, refreshed only at a wrap, a sync or a reset, so a mid-period
// change can never shorten or lengthen the period already in progress.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         sync,
    input  logic         mode,
    input  logic [W-1:0] scale,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic [W-1:0] act_scale_reg;
    logic [W-1:0] act_scale_next;
    mode_e        act_mode_reg;
    mode_e        act_mode_next;
    logic         out_reg;
    logic         out_next;
    logic         tick_reg;
    logic         tick_next;

    logic [W-1:0] div;
    logic         wrap;

    // Effective divisor and period-boundary detect; a zero scale behaves
    // as divide-by-one so the channel never stalls.
    always_comb begin
        div  = (act_scale_reg == '0) ? W'(1) : act_scale_reg;
        wrap = enable && (cnt_reg == div - W'(1));
    end

    // Next-state for the free-running part: count, wrap with shadow
    // reload, and pulse-mode return to low on every non-wrap cycle.
    always_comb begin
        cnt_next       = cnt_reg;
        act_scale_next = act_scale_reg;
        act_mode_next  = act_mode_reg;
        out_next       = out_reg;
        tick_next      = 1'b0;
        if (wrap) begin
            cnt_next       = '0;
            tick_next      = 1'b1;
            act_scale_next = scale;
            act_mode_next  = mode_e'(mode);
            // Shape with the mode of the period that is ending.
            out_next       = (act_mode_reg == MODE_PULSE) ? 1'b1 : ~out_reg;
        end else begin
            if (enable) begin
                cnt_next = cnt_reg + W'(1);
            end
            if (act_mode_reg == MODE_PULSE) begin
                out_next = 1'b0;
            end
        end
    end

    // State register: reset and sync both restart the phase and reload
    // the shadows from the live inputs; sync acts even while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            act_scale_reg <= scale;
            act_mode_reg  <= mode_e'(mode);
            out_reg       <= 1'b0;
            tick_reg      <= 1'b0;
        end else if (sync) begin
            cnt_reg       <= '0;
            act_scale_reg <= scale;
            act_mode_reg  <= mode_e'(mode);
            out_reg       <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            act_scale_reg <= act_scale_next;
            act_mode_reg  <= act_mode_next;
            out_reg       <= out_next;
            tick_reg      <= tick_next;
        end
    end

    assign clk_out = out_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel clock-enable divider. Channels are fully independent; this
// level only replicates the channel and slices the flattened scale bus.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   enable,
    input  logic [NCH-1:0]   sync,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH*W-1:0] scale,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            clk_div_chan #(
                .W(W)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .enable  (enable[gi]),
                .sync    (sync[gi]),
                .mode    (mode[gi]),
                .scale   (scale[gi*W +: W]),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a countdown model checked every cycle,
// plus hand-computed edge positions that pin the model's behaviour.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   enable;
    logic [NCH-1:0]   sync;
    logic [NCH-1:0]   mode;
    logic [NCH*W-1:0] scale;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int checks   = 0;
    int failures = 0;

    clk_div_multi #(.NCH(NCH), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .sync    (sync),
        .mode    (mode),
        .scale   (scale),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Model: cycles left until the next wrap, the output level, the tick
    // and the mode of the running period, per channel.
    longint left_m [NCH];
    bit     lvl_m  [NCH];
    bit     tk_m   [NCH];
    bit     cm_m   [NCH];
    bit     model_valid = 1'b0;

    function automatic longint eff_div(input logic [W-1:0] s);
        return (s == 0) ? 64'd1 : longint'(s);
    endfunction

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            if (reset || sync[i]) begin
                left_m[i] = eff_div(scale[i*W +: W]);
                cm_m[i]   = mode[i];
                lvl_m[i]  = 1'b0;
                tk_m[i]   = 1'b0;
            end else if (enable[i]) begin
                left_m[i] = left_m[i] - 1;
                if (left_m[i] == 0) begin
                    tk_m[i]   = 1'b1;
                    lvl_m[i]  = cm_m[i] ? 1'b1 : ~lvl_m[i];
                    cm_m[i]   = mode[i];
                    left_m[i] = eff_div(scale[i*W +: W]);
                end else begin
                    tk_m[i] = 1'b0;
                    if (cm_m[i]) lvl_m[i] = 1'b0;
                end
            end else begin
                tk_m[i] = 1'b0;
                if (cm_m[i]) lvl_m[i] = 1'b0;
            end
        end
        if (reset) model_valid = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        logic [NCH-1:0] eo;
        logic [NCH-1:0] et;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int i = 0; i < NCH; i++) begin
                    eo[i] = lvl_m[i];
                    et[i] = tk_m[i];
                end
                checks++;
                if (clk_out !== eo || tick !== et) begin
                    failures++;
                    $display("FAIL cycle_cmp t=%0t clk_out=%b tick=%b required clk_out=%b tick=%b",
                             $time, clk_out, tick, eo, et);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_sc(input int ch, input int v);
        scale[ch*W +: W] = W'(v);
    endtask

    task automatic pulse_sync(input logic [NCH-1:0] m);
        sync = m;
        @(negedge clk);
        sync = '0;
    endtask

    initial begin
        int  first_rise, first_fall, second_rise, ticks0, h1, h2, h3;
        int  tr[4];
        int  k, gap_ticks, r0, f0, r3, f3;
        bit  prev, prev3, seen;

        reset  = 1'b1;
        enable = '1;
        sync   = '0;
        mode   = 4'b1010;
        scale  = '0;
        set_sc(0, 1000);
        set_sc(1, 4);
        set_sc(2, 1);
        set_sc(3, 0);

        // Reset for five edges, outputs must be zero.
        repeat (5) @(negedge clk);
        chk("reset_outputs", longint'({clk_out, tick}), 0);
        reset = 1'b0;
        $display("reset: 5 cycles, released");

        // Basic toggle on ch0, pulse/scale-0/clk-2 on ch1..3.
        first_rise = -1; first_fall = -1; second_rise = -1;
        ticks0 = 0; h1 = 0; h2 = 0; h3 = 0; prev = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n <= 40) begin
                h1 += int'(clk_out[1]);
                h2 += int'(clk_out[2]);
                h3 += int'(clk_out[3]);
            end
            ticks0 += int'(tick[0]);
            if (clk_out[0] && !prev) begin
                if (first_rise < 0) first_rise = n;
                else if (second_rise < 0) second_rise = n;
            end
            if (!clk_out[0] && prev && first_fall < 0) first_fall = n;
            prev = clk_out[0];
        end
        chk("toggle1000_first_rise", first_rise, 1000);
        chk("toggle1000_first_fall", first_fall, 2000);
        chk("toggle1000_second_rise", second_rise, 3000);
        chk("toggle1000_ticks", ticks0, 3);
        chk("pulse4_high_cycles_of_40", h1, 10);
        chk("toggle1_high_cycles_of_40", h2, 20);
        chk("pulse0_high_cycles_of_40", h3, 40);
        $display("basic: rise=%0d fall=%0d rise2=%0d ticks=%0d h1=%0d h2=%0d h3=%0d",
                 first_rise, first_fall, second_rise, ticks0, h1, h2, h3);

        // Glitch-free reload: scale 10 -> 3 at cnt=5.
        set_sc(0, 10);
        pulse_sync(4'b0001);
        for (int j = 0; j < 4; j++) tr[j] = -1;
        k = 0; prev = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 5) set_sc(0, 3);
            if (clk_out[0] != prev && k < 4) begin
                tr[k] = n;
                k++;
            end
            prev = clk_out[0];
        end
        chk("reload_edge0", tr[0], 10);
        chk("reload_edge1", tr[1], 13);
        chk("reload_edge2", tr[2], 16);
        chk("reload_edge3", tr[3], 19);
        $display("reload: edges %0d %0d %0d %0d", tr[0], tr[1], tr[2], tr[3]);

        // Enable gap of 5 cycles inside the high half of a scale-8 period.
        set_sc(0, 8);
        pulse_sync(4'b0001);
        for (int j = 0; j < 4; j++) tr[j] = -1;
        k = 0; prev = 1'b0; gap_ticks = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n >= 11 && n <= 15) gap_ticks += int'(tick[0]);
            if (clk_out[0] != prev && k < 4) begin
                tr[k] = n;
                k++;
            end
            prev = clk_out[0];
            if (n == 10) enable[0] = 1'b0;
            if (n == 15) enable[0] = 1'b1;
        end
        chk("gap_rise", tr[0], 8);
        chk("gap_fall", tr[1], 21);
        chk("gap_period", tr[1] - tr[0], 13);
        chk("gap_ticks", gap_ticks, 0);
        $display("gap: rise=%0d fall=%0d ticks_in_gap=%0d", tr[0], tr[1], gap_ticks);

        // Phase alignment of ch0 and ch3 via a shared sync.
        mode[3] = 1'b0;
        set_sc(3, 6);
        set_sc(0, 6);
        repeat (17) @(negedge clk);
        pulse_sync(4'b1001);
        r0 = -1; f0 = -1; r3 = -1; f3 = -1; prev = 1'b0; prev3 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (clk_out[0] && !prev && r0 < 0) r0 = n;
            if (!clk_out[0] && prev && f0 < 0) f0 = n;
            if (clk_out[3] && !prev3 && r3 < 0) r3 = n;
            if (!clk_out[3] && prev3 && f3 < 0) f3 = n;
            prev = clk_out[0];
            prev3 = clk_out[3];
        end
        chk("align_ch0_rise", r0, 6);
        chk("align_ch0_fall", f0, 12);
        chk("align_ch3_rise", r3, 6);
        chk("align_ch3_fall", f3, 12);
        $display("align: ch0 %0d/%0d ch3 %0d/%0d", r0, f0, r3, f3);

        // Sync while disabled clears a held-high toggle output.
        seen = 1'b0;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(negedge clk);
            seen = clk_out[2];
        end
        chk("ch2_high_before_disable", longint'(clk_out[2]), 1);
        enable[2] = 1'b0;
        @(negedge clk);
        chk("ch2_hold_while_disabled", longint'(clk_out[2]), 1);
        pulse_sync(4'b0100);
        chk("ch2_sync_disabled_clears", longint'(clk_out[2]), 0);
        repeat (3) @(negedge clk);
        chk("ch2_stays_low_disabled", longint'(clk_out[2]), 0);
        enable[2] = 1'b1;
        $display("sync_disabled: ch2 cleared");

        // Reset coinciding with sync and a ch2 wrap, new ch0 scale 5.
        set_sc(0, 5);
        reset = 1'b1;
        sync  = '1;
        @(negedge clk);
        chk("reset_mid_outputs", longint'({clk_out, tick}), 0);
        reset = 1'b0;
        sync  = '0;
        r0 = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (clk_out[0] && r0 < 0) r0 = n;
        end
        chk("reset_mid_ch0_first_rise", r0, 5);
        $display("reset_mid: ch0 first rise=%0d", r0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
